// File: rtl/eprisc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eprisc_io_pkg
// Brief   : Shared constants, state encodings and helpers for the epRISC
//           I/O bus controller and its UART receiver.
// Rev     : 1.0  initial release
// ============================================================================
package eprisc_io_pkg;

    // Register map (7-bit address carried in the command byte)
    localparam logic [6:0] ADDR_STATUS  = 7'h00;
    localparam logic [6:0] ADDR_RXDATA  = 7'h01;
    localparam logic [6:0] ADDR_TXDATA  = 7'h02;
    localparam logic [6:0] ADDR_CONTROL = 7'h03;
    localparam logic [6:0] ADDR_DIVLO   = 7'h04;
    localparam logic [6:0] ADDR_DIVHI   = 7'h05;

    // STATUS bit positions
    localparam int STAT_RX_NE    = 0;
    localparam int STAT_TX_BUSY  = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_FRAMING  = 3;

    // Smallest usable bit period: the receiver needs a half period of >= 2
    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_CMD  = 2'd1,
        BUS_DATA = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eprisc_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : eprisc_uart_rx
// Brief   : 8N1 UART receiver with input synchroniser, glitch rejection,
//           framing detection and a small receive FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module eprisc_uart_rx
    import eprisc_io_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_async,
    input  logic        flush,
    input  logic [15:0] divisor,
    input  logic        pop,
    output logic [7:0]  head,
    output logic        not_empty,
    output logic        overrun_evt,
    output logic        framing_evt
);

    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RX_DEPTH);

    logic              rx_meta;
    logic              rx_sync;
    uart_state_t       state;
    uart_state_t       state_next;
    logic [15:0]       cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              armed;
    logic [15:0]       half_m1;
    logic [15:0]       div_m1;
    logic              half_end;
    logic              period_end;
    logic              bit_sample;
    logic              stop_sample;
    logic              push_req;

    logic [7:0]        mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign half_m1     = (divisor >> 1) - 16'd1;
    assign div_m1      = divisor - 16'd1;
    assign half_end    = (state == UART_START) && (cnt == half_m1);
    assign period_end  = ((state == UART_DATA) || (state == UART_STOP)) && (cnt == div_m1);
    assign bit_sample  = (state == UART_DATA) && period_end;
    assign stop_sample = (state == UART_STOP) && period_end;
    assign push_req    = stop_sample && rx_sync && !flush;
    assign framing_evt = stop_sample && !rx_sync && !flush;

    assign full        = (count == DEPTH_C);
    assign not_empty   = (count != '0);
    assign do_pop      = pop && not_empty && !flush;
    // A full FIFO that is popped in the same cycle still has room
    assign do_push     = push_req && (!full || do_pop);
    assign overrun_evt = push_req && full && !do_pop;
    assign head        = mem[rd_ptr];

    // Two-flop synchroniser on the serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_async;
            rx_sync <= rx_meta;
        end
    end

    // Receive state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UART_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Receive next-state logic: glitch check at half bit, then 8 data bits and stop
    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (armed && !rx_sync) state_next = UART_START;
            UART_START: if (half_end) state_next = rx_sync ? UART_IDLE : UART_DATA;
            UART_DATA:  if (period_end && (bit_idx == 3'd7)) state_next = UART_STOP;
            UART_STOP:  if (period_end) state_next = UART_IDLE;
            default:    state_next = UART_IDLE;
        endcase
        if (flush) state_next = UART_IDLE;
    end

    // Bit timing, data shift register and re-arm tracking after a framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            armed   <= 1'b0;
        end else if (flush) begin
            cnt     <= '0;
            bit_idx <= '0;
            armed   <= 1'b0;
        end else begin
            cnt <= ((state == UART_IDLE) || half_end || period_end) ? 16'd0 : cnt + 16'd1;
            if (state == UART_IDLE) begin
                bit_idx <= '0;
                if (rx_sync) armed <= 1'b1;
            end
            if (bit_sample) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (stop_sample && !rx_sync) armed <= 1'b0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

endmodule
`default_nettype wire

// File: rtl/eprisc_io_controller.sv
`default_nettype none
// ============================================================================
// Module  : eprisc_io_controller
// Brief   : epRISC I/O bus peripheral: byte-wide command/data register
//           access, 8N1 UART transmitter, receive path and interrupt.
// Rev     : 1.0  initial release
// ============================================================================
module eprisc_io_controller
    import eprisc_io_pkg::*;
#(
    parameter int         CLKS_PER_BIT  = 256,
    parameter logic [1:0] DEVICE_SELECT = 2'b01,
    parameter int         RX_DEPTH      = 4
) (
    input  logic       iBoardClock,
    input  logic       iBoardReset,
    input  logic       iBusClock,
    input  logic [1:0] iBusSelect,
    input  logic [7:0] iBusMOSI,
    output logic [7:0] oBusMISO,
    output logic       oBusInterrupt,
    input  logic       iTTLSerialRX,
    output logic       oTTLSerialTX,
    input  logic       iTTLSerialRST
);

    localparam logic [15:0] DIV_RESET = 16'(CLKS_PER_BIT);

    logic        clk;
    logic        rst_n;
    assign clk   = iBoardClock;
    assign rst_n = iBoardReset;

    // Synchronised bus and flush inputs
    logic       bus_clk_meta, bus_clk_sync, bus_clk_prev;
    logic [1:0] sel_meta, sel_sync;
    logic [7:0] mosi_meta, mosi_sync;
    logic       flush_meta, flush_sync;

    // Bus decode
    bus_state_t bus_state, bus_next;
    logic       sel_match, byte_strobe, cmd_byte, data_byte;
    logic [7:0] cmd_reg, wr_data, rd_value, miso;
    logic       read_go, wr_go;
    logic [6:0] reg_addr;

    // Registers and flags
    logic [7:0]  control;
    logic [15:0] divisor;
    logic        overrun, framing, irq;

    // Receiver interface
    logic [7:0] rx_head;
    logic       rx_not_empty, rx_pop, rx_overrun_evt, rx_framing_evt;

    // Transmitter
    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_line, tx_start, tx_tick, tx_busy;

    assign sel_match   = (sel_sync == DEVICE_SELECT);
    assign byte_strobe = bus_clk_sync && !bus_clk_prev && sel_match;
    assign cmd_byte    = byte_strobe && (bus_state != BUS_CMD);
    assign data_byte   = byte_strobe && (bus_state == BUS_CMD);
    assign reg_addr    = cmd_reg[6:0];
    assign rx_pop      = read_go && (reg_addr == ADDR_RXDATA);
    assign tx_busy     = (tx_state != UART_IDLE);
    assign tx_tick     = tx_busy && (tx_cnt == divisor - 16'd1);
    assign tx_start    = wr_go && (reg_addr == ADDR_TXDATA) && !tx_busy && !flush_sync;

    assign oBusMISO      = miso;
    assign oBusInterrupt = irq;
    assign oTTLSerialTX  = tx_line;

    // Two-flop synchronisers for the bus and flush inputs, plus strobe history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_clk_meta <= 1'b0;
            bus_clk_sync <= 1'b0;
            bus_clk_prev <= 1'b0;
            sel_meta     <= '0;
            sel_sync     <= '0;
            mosi_meta    <= '0;
            mosi_sync    <= '0;
            flush_meta   <= 1'b0;
            flush_sync   <= 1'b0;
        end else begin
            bus_clk_meta <= iBusClock;
            bus_clk_sync <= bus_clk_meta;
            bus_clk_prev <= bus_clk_sync;
            sel_meta     <= iBusSelect;
            sel_sync     <= sel_meta;
            mosi_meta    <= iBusMOSI;
            mosi_sync    <= mosi_meta;
            flush_meta   <= iTTLSerialRST;
            flush_sync   <= flush_meta;
        end
    end

    // Bus state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state <= BUS_IDLE;
        end else begin
            bus_state <= bus_next;
        end
    end

    // Bus next state: bytes alternate command/data while selected
    always_comb begin
        bus_next = bus_state;
        if (!sel_match) begin
            bus_next = BUS_IDLE;
        end else if (byte_strobe) begin
            case (bus_state)
                BUS_IDLE, BUS_DATA: bus_next = BUS_CMD;
                BUS_CMD:            bus_next = BUS_DATA;
                default:            bus_next = BUS_IDLE;
            endcase
        end
    end

    // Command capture, one-cycle read/write launches and the MISO holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg <= '0;
            wr_data <= '0;
            read_go <= 1'b0;
            wr_go   <= 1'b0;
            miso    <= '0;
        end else begin
            read_go <= cmd_byte && mosi_sync[7];
            wr_go   <= data_byte && !cmd_reg[7];
            if (cmd_byte)  cmd_reg <= mosi_sync;
            if (data_byte) wr_data <= mosi_sync;
            if (read_go) begin
                miso <= rd_value;
            end else if (data_byte || !sel_match) begin
                miso <= '0;
            end
        end
    end

    // Read multiplexer
    always_comb begin
        rd_value = '0;
        case (reg_addr)
            ADDR_STATUS: begin
                rd_value[STAT_RX_NE]   = rx_not_empty;
                rd_value[STAT_TX_BUSY] = tx_busy;
                rd_value[STAT_OVERRUN] = overrun;
                rd_value[STAT_FRAMING] = framing;
            end
            ADDR_RXDATA:  rd_value = rx_not_empty ? rx_head : 8'h00;
            ADDR_CONTROL: rd_value = control;
            ADDR_DIVLO:   rd_value = divisor[7:0];
            ADDR_DIVHI:   rd_value = divisor[15:8];
            default:      rd_value = '0;
        endcase
    end

    // Register writes, sticky error flags and registered interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control <= '0;
            divisor <= DIV_RESET;
            overrun <= 1'b0;
            framing <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_go) begin
                case (reg_addr)
                    ADDR_CONTROL: control <= wr_data;
                    ADDR_DIVLO:   divisor <= clamp_divisor({divisor[15:8], wr_data});
                    ADDR_DIVHI:   divisor <= clamp_divisor({wr_data, divisor[7:0]});
                    default:      ;
                endcase
            end
            // A new error in the same cycle as the clearing read survives it
            if (read_go && (reg_addr == ADDR_STATUS)) begin
                overrun <= rx_overrun_evt;
                framing <= rx_framing_evt;
            end else begin
                overrun <= overrun | rx_overrun_evt;
                framing <= framing | rx_framing_evt;
            end
            irq <= control[0] && rx_not_empty;
        end
    end

    // Transmit state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= UART_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // Transmit next state: start, 8 data bits, stop, one divisor period each
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            UART_IDLE:  if (tx_start) tx_next = UART_START;
            UART_START: if (tx_tick) tx_next = UART_DATA;
            UART_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = UART_STOP;
            UART_STOP:  if (tx_tick) tx_next = UART_IDLE;
            default:    tx_next = UART_IDLE;
        endcase
        if (flush_sync) tx_next = UART_IDLE;
    end

    // Transmit bit timer, shift register and line driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else if (flush_sync) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_line <= 1'b1;
        end else begin
            tx_cnt <= (!tx_busy || tx_tick) ? 16'd0 : tx_cnt + 16'd1;
            if (tx_start) begin
                tx_shift <= wr_data;
                tx_bit   <= '0;
                tx_line  <= 1'b0;
            end else if (tx_tick) begin
                case (tx_state)
                    UART_START: tx_line <= tx_shift[0];
                    UART_DATA: begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_line  <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
                    end
                    default: tx_line <= 1'b1;
                endcase
            end
        end
    end

    eprisc_uart_rx #(
        .RX_DEPTH (RX_DEPTH)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_async    (iTTLSerialRX),
        .flush       (flush_sync),
        .divisor     (divisor),
        .pop         (rx_pop),
        .head        (rx_head),
        .not_empty   (rx_not_empty),
        .overrun_evt (rx_overrun_evt),
        .framing_evt (rx_framing_evt)
    );

endmodule
`default_nettype wire

// File: tb/tb_eprisc_io_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_eprisc_io_controller
// Brief   : Self-checking bench for eprisc_io_controller with a receive
//           scoreboard and a status-flag model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_eprisc_io_controller;

    localparam int BIT = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       bus_clk = 1'b0;
    logic [1:0] sel = 2'b01;
    logic [7:0] mosi = 8'h00;
    logic [7:0] miso;
    logic       irq;
    logic       rx = 1'b1;
    logic       tx;
    logic       flush = 1'b0;

    int checks = 0;
    int errors = 0;

    // Scoreboard of bytes the FIFO should hold, plus the status-flag model
    logic [7:0] rx_q[$];
    logic       exp_overrun = 1'b0;
    logic       exp_framing = 1'b0;
    logic       tx_q[$];

    eprisc_io_controller dut (
        .iBoardClock   (clk),
        .iBoardReset   (rst_n),
        .iBusClock     (bus_clk),
        .iBusSelect    (sel),
        .iBusMOSI      (mosi),
        .oBusMISO      (miso),
        .oBusInterrupt (irq),
        .iTTLSerialRX  (rx),
        .oTTLSerialTX  (tx),
        .iTTLSerialRST (flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_byte(input logic [7:0] b);
        mosi = b;
        wait_clks(3);
        bus_clk = 1'b1;
        wait_clks(8);
        bus_clk = 1'b0;
        wait_clks(8);
    endtask

    task automatic bus_read(input logic [6:0] addr, output logic [7:0] d);
        mosi = {1'b1, addr};
        wait_clks(3);
        bus_clk = 1'b1;
        wait_clks(8);
        d = miso;
        bus_clk = 1'b0;
        wait_clks(8);
        bus_byte(8'h00);
    endtask

    task automatic bus_write(input logic [6:0] addr, input logic [7:0] d);
        bus_byte({1'b0, addr});
        bus_byte(d);
        wait_clks(3);
    endtask

    task automatic uart_frame(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        rx = stop_ok;
        wait_clks(BIT);
        rx = 1'b1;
        if (stop_ok) begin
            if (rx_q.size() < 4) rx_q.push_back(b);
            else exp_overrun = 1'b1;
        end else begin
            exp_framing = 1'b1;
        end
        wait_clks(40);
    endtask

    task automatic check_status(input string name, input logic busy);
        logic [7:0] got, exp;
        exp = {4'b0, exp_framing, exp_overrun, busy, (rx_q.size() != 0)};
        bus_read(7'h00, got);
        exp_framing = 1'b0;
        exp_overrun = 1'b0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: STATUS got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic check_rxdata(input string name);
        logic [7:0] got, exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        bus_read(7'h01, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: RXDATA got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        #5 rst_n = 1'b0;
        #45;
        check_bit("reset_tx", tx, 1'b1);
        check_bit("reset_irq", irq, 1'b0);
        checks++;
        if (miso !== 8'h00) begin
            errors++;
            $display("FAIL reset_miso: got 0x%02h expected 0x00", miso);
        end
        #50 rst_n = 1'b1;
        wait_clks(10);
        check_status("reset_status", 1'b0);
        bus_read(7'h04, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_divlo: got 0x%02h expected 0x00", d);
        end
        bus_read(7'h05, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL reset_divhi: got 0x%02h expected 0x01", d);
        end
    endtask

    task automatic test_rx_single();
        bus_write(7'h03, 8'h01);
        uart_frame(8'h41, 1'b1);
        check_bit("rx_irq_set", irq, 1'b1);
        check_status("rx_status_ne", 1'b0);
        check_rxdata("rx_byte_41");
        wait_clks(5);
        check_bit("rx_irq_clear", irq, 1'b0);
    endtask

    task automatic test_rx_overrun();
        for (int i = 0; i < 5; i++) uart_frame(8'h31 + 8'(i), 1'b1);
        check_status("overrun_status", 1'b0);
        for (int i = 0; i < 4; i++) check_rxdata("overrun_read");
        check_status("overrun_drained", 1'b0);
        check_rxdata("empty_read");
        check_bit("overrun_irq_clear", irq, 1'b0);
    endtask

    task automatic test_framing();
        uart_frame(8'h5A, 1'b0);
        wait_clks(BIT);
        check_status("framing_status", 1'b0);
        check_status("framing_cleared", 1'b0);
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        wait_clks(100);
        rx = 1'b1;
        wait_clks(600);
        check_status("glitch_none", 1'b0);
        uart_frame(8'h0E, 1'b1);
        check_status("glitch_after_ne", 1'b0);
        check_rxdata("glitch_after_0e");
    endtask

    task automatic test_tx();
        logic [7:0] txb;
        txb = 8'h55;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(txb[i]);
        tx_q.push_back(1'b1);
        fork
            begin
                int n;
                n = 0;
                while (tx !== 1'b0 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n >= 300) begin
                    errors++;
                    $display("FAIL tx_start_timeout: tx got %b expected 0 within 300 clocks", tx);
                end
                wait_clks(BIT / 2);
                for (int i = 0; i < 10; i++) begin
                    logic e;
                    e = tx_q.pop_front();
                    check_bit("tx_bit", tx, e);
                    wait_clks(BIT);
                end
            end
            begin
                bus_write(7'h02, 8'h55);
                wait_clks(500);
                check_status("tx_busy_early", 1'b1);
                bus_write(7'h02, 8'hAA);
                wait_clks(1500);
                check_status("tx_busy_late", 1'b1);
            end
        join
        wait_clks(20);
        check_status("tx_idle_after", 1'b0);
        wait_clks(2 * BIT);
        check_bit("tx_line_idle", tx, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_overrun();
        test_framing();
        test_glitch();
        test_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eprisc_io_controller.md
Name: eprisc_io_controller

Overview:
- Peripheral-side controller of the epRISC I/O bus.
- It decodes byte transactions from the CPU's 8-bit parallel bus master into a small register file.
- It implements a TTL 8N1 UART with a 4-entry receive FIFO and raises the bus interrupt on received data.
- RS-232, GPIO, SPI-card, VGA and PS/2 functions are separate blocks outside this scope.

Parameters:
- CLKS_PER_BIT, 256, reset value of the UART bit period in iBoardClock cycles.
- DEVICE_SELECT, 2'b01, iBusSelect value that addresses this controller.
- RX_DEPTH, 4, depth of the receive FIFO; must be a power of two.

Ports:
- iBoardClock  in  1  system clock.
- iBoardReset  in  1  asynchronous, active-low reset.
- iBusClock  in  1  bus strobe from the master; sampled as data.
- iBusSelect  in  2  device select.
- iBusMOSI  in  8  master-to-slave byte.
- oBusMISO  out  8  slave-to-master byte.
- oBusInterrupt  out  1  level interrupt, active high.
- iTTLSerialRX  in  1  UART receive, idles high.
- oTTLSerialTX  out  1  UART transmit, idles high.
- iTTLSerialRST  in  1  UART flush request, active high.

Behaviour:
- Clocking and reset
  - One clock domain: iBoardClock.
  - Reset is asynchronous and active-low on iBoardReset.
  - All asynchronous inputs pass through 2-flop synchronisers.
  - Values held while in reset:
    - oTTLSerialTX=1, oBusMISO=0, oBusInterrupt=0.
    - FIFO empty, all flags 0, CONTROL=0.
    - DIVISOR=CLKS_PER_BIT, bus state IDLE.
- Bus protocol
  - A byte is taken on each synchronised rising edge of iBusClock while iBusSelect==DEVICE_SELECT.
  - Select changing to any other value returns the bus FSM to IDLE immediately.
  - FSM sequence: IDLE → CMD on the first byte → DATA on the second byte → back to CMD, ready for the next command.
  - Command byte: bit7 = 1 for read, 0 for write; bits6:0 = register address.
  - Read: oBusMISO holds the register value from 2 cycles after the command edge until the data edge.
  - Write: the data byte commits 1 cycle after its edge.
- Registers
  - 0x00 STATUS, read-only:
    - b0 RX not empty; b1 TX busy; b2 RX overrun; b3 framing error.
    - Reading STATUS clears b2 and b3.
  - 0x01 RXDATA, read: returns the FIFO head and pops it. Reading while empty returns 0x00 and does not pop.
  - 0x02 TXDATA, write: starts transmission when TX is idle. A write while busy is ignored.
  - 0x03 CONTROL, read/write: b0 = RX interrupt enable.
  - 0x04 DIVLO and 0x05 DIVHI, read/write: 16-bit DIVISOR. Values below 4 are clamped to 4.
  - Any other address reads 0x00; writes to it are ignored.
- Interrupt
  - oBusInterrupt = CONTROL.b0 AND FIFO-not-empty, registered.
- UART receiver
  - Idle until the synchronised RX falls.
  - Re-samples at DIVISOR/2. If RX is high there, the event is a glitch: return to idle.
  - Then 8 data bits, LSB first, each sampled DIVISOR cycles apart.
  - Stop bit sampled one DIVISOR later:
    - High: the byte is pushed to the FIFO.
    - Low: framing error set, byte discarded, and RX must return high before the next start is armed.
  - A push while the FIFO is full drops the new byte and sets overrun.
  - A same-cycle push and pop on a full FIFO both succeed.
- UART transmitter
  - Sends start, 8 data bits LSB first, then stop; each bit lasts DIVISOR cycles.
  - Busy is set from the write until the stop bit ends.
- Flush (iTTLSerialRST)
  - Synchronised iTTLSerialRST high empties the FIFO, aborts RX and TX, and drives TX high.
  - Registers are unaffected.

Decomposition:
- Package eprisc_io_pkg:
  - Register address constants.
  - STATUS bit indices.
  - Bus FSM enum (IDLE/CMD/DATA).
  - UART FSM enum (IDLE/START/DATA/STOP).
- Sub-module eprisc_uart_rx: synchroniser, receive FSM and FIFO push.
- Transmitter and bus logic stay in the top level.

Test Plan:
1. Reset low at t=5, released at t=100 → oTTLSerialTX=1, oBusInterrupt=0; reading STATUS returns 0x00 and reading DIVLO returns 0x00 (DIVISOR=256).
2. Write CONTROL=0x01, then drive RX with frame 0x41 at 256 clocks/bit → within 10 bit periods oBusInterrupt=1 and STATUS=0x01; reading RXDATA returns 0x41, after which oBusInterrupt=0.
3. Send 5 frames (0x31–0x35) with no reads → STATUS=0x05; reads return 0x31..0x34, then STATUS=0x00.
4. Frame with stop bit low → STATUS b3=1 and FIFO empty; a second STATUS read returns 0x00.
5. RX low pulse of 100 clocks → no byte is received; a following valid frame 0x0E is received correctly.
6. Write TXDATA=0x55 → TX shows start then 1,0,1,0,1,0,1,0 then stop, each bit 256 clocks; STATUS b1=1 throughout, 0 afterwards; a second TXDATA write mid-frame is ignored.
